// File: rtl/ifm_rd_resp.sv
// ifm_rd_resp: read responder for the input-feature-map buffer.
// Accepts DMA read addresses, issues fixed-latency SRAM reads, and returns the
// data through a small first-word-fall-through FIFO. Address acceptance is
// credit-limited so every read issued is guaranteed a FIFO slot on return.
module ifm_rd_resp #(
    parameter int DW = 64,
    parameter int AW = 14,
    parameter int RL = 1,
    parameter int FD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] m_addr,
    input  logic          m_addr_first,
    input  logic          m_addr_last,
    input  logic          m_addr_valid,
    output logic          m_addr_ready,
    output logic          mem_ren,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] s_data,
    output logic          s_data_first,
    output logic          s_data_last,
    output logic          s_data_valid,
    input  logic          s_data_ready,
    output logic          busy,
    output logic          err_proto
);

    localparam int PW = $clog2(FD);
    localparam int CW = PW + 1;
    localparam logic [CW:0] FD_SLOTS = (CW + 1)'(FD);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state;
    logic            err_q;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     slots;
    logic            accept;
    logic            push;
    logic            pop;
    logic [AW-1:0]   raddr_q;
    logic [RL:1]     tag_vld_p;
    logic [RL:1]     tag_first_p;
    logic [RL:1]     tag_last_p;
    logic [DW+1:0]   fifo_mem [FD];
    logic [DW+1:0]   head;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    // Credits are taken from registered counts only, so a pop frees its slot
    // one cycle later and s_data_ready never reaches m_addr_ready.
    assign slots        = {1'b0, fifo_count} + {1'b0, inflight};
    assign m_addr_ready = (slots < FD_SLOTS) && !rst;
    assign accept       = m_addr_valid && m_addr_ready;
    assign push         = tag_vld_p[RL];
    assign pop          = s_data_valid && s_data_ready;

    // The SRAM address passes straight through on an accept and holds otherwise.
    assign mem_ren      = accept;
    assign mem_raddr    = accept ? m_addr : raddr_q;

    assign head         = fifo_mem[rd_ptr];
    assign s_data_valid = (fifo_count != '0);
    assign s_data       = s_data_valid ? head[DW+1:2] : '0;
    assign s_data_first = s_data_valid ? head[1] : 1'b0;
    assign s_data_last  = s_data_valid ? head[0] : 1'b0;

    // The beat being accepted counts as activity so busy rises with the request.
    assign busy         = (state == BURST) || (inflight != '0) ||
                          (fifo_count != '0) || accept;
    assign err_proto    = err_q;

    // Remember the last issued read address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q <= '0;
        end else if (accept) begin
            raddr_q <= m_addr;
        end
    end

    // Tag valid pipeline: a set bit at stage RL marks mem_rdata as a live return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_vld_p <= '0;
        end else begin
            tag_vld_p[1] <= accept;
            for (int k = 2; k <= RL; k++) begin
                tag_vld_p[k] <= tag_vld_p[k-1];
            end
        end
    end

    // First/last tags ride alongside the valid pipeline; qualified by tag_vld_p.
    always_ff @(posedge clk) begin
        tag_first_p[1] <= m_addr_first;
        tag_last_p[1]  <= m_addr_last;
        for (int k = 2; k <= RL; k++) begin
            tag_first_p[k] <= tag_first_p[k-1];
            tag_last_p[k]  <= tag_last_p[k-1];
        end
    end

    // Count reads issued but not yet written into the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
        end else if (accept && !push) begin
            inflight <= inflight + 1'b1;
        end else if (!accept && push) begin
            inflight <= inflight - 1'b1;
        end
    end

    // FIFO storage: returning data and its tags, written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {mem_rdata, tag_first_p[RL], tag_last_p[RL]};
        end
    end

    // FIFO pointers and occupancy; depth is a power of two so pointers wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + 1'b1;
            end else if (!push && pop) begin
                fifo_count <= fifo_count - 1'b1;
            end
        end
    end

    // Burst framing tracker with a sticky protocol-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (!m_addr_first) begin
                        err_q <= 1'b1;
                    end else if (!m_addr_last) begin
                        state <= BURST;
                    end
                end
                BURST: begin
                    if (m_addr_first) begin
                        err_q <= 1'b1;
                    end
                    if (m_addr_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
